fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 122 ++++++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end. A PC register issues sequential fetches to a
// fixed one-cycle-latency ROM. The returned instructions go into a small FIFO
// that feeds decode. A redirect (flush_i) drops everything that is queued or
// in flight and restarts fetching at new_pc_i.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   rom_addr_o  out  fetch address (current PC)
//   rom_ce_o    out  fetch request; the ROM samples rom_addr_o when high
//   rom_data_i  in   instruction for the address requested in the previous cycle
//   flush_i     in   redirect; discard all queued and in-flight instructions
//   new_pc_i    in   redirect target, valid while flush_i is high
//   id_valid_o  out  head entry is valid toward decode
//   id_pc_o     out  PC of the head entry
//   id_inst_o   out  instruction of the head entry
//   id_ready_i  in   decode accepts the head entry this cycle
//   count_o     out  current queue occupancy
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDR_W-1:0]         rom_addr_o,
  output logic                      rom_ce_o,
  input  logic [DATA_W-1:0]         rom_data_i,
  input  logic                      flush_i,
  input  logic [ADDR_W-1:0]         new_pc_i,
  output logic                      id_valid_o,
  output logic [ADDR_W-1:0]         id_pc_o,
  output logic [DATA_W-1:0]         id_inst_o,
  input  logic                      id_ready_i,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_req_pc;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [DATA_W-1:0] r_inst_mem [DEPTH];

  logic [CW:0]       w_occupied;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;

  // Credit check counts the in-flight request as already occupying a slot.
  // A pop in the same cycle is deliberately not credited, which keeps the
  // issue decision off the decode-ready path.
  assign w_occupied = {1'b0, r_count} + (CW+1)'(r_inflight);
  assign w_issue    = !rst && !flush_i && (w_occupied < (CW+1)'(DEPTH));

  // The ROM answer for last cycle's request lands now, unless a redirect
  // in this cycle makes it stale.
  assign w_push     = r_inflight && !flush_i;

  assign w_valid    = (r_count != '0) && !flush_i && !rst;
  assign w_pop      = w_valid && id_ready_i;

  assign rom_addr_o = r_pc;
  assign rom_ce_o   = w_issue;
  assign id_valid_o = w_valid;
  assign id_pc_o    = r_pc_mem[r_head];
  assign id_inst_o  = r_inst_mem[r_head];
  assign count_o    = r_count;

  // Control state: PC, in-flight tracking, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (flush_i) begin
      // Clearing the in-flight flag drops the response arriving next cycle.
      r_pc       <= new_pc_i;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_pc;
        r_pc     <= r_pc + ADDR_W'(4);
      end
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Queue storage; contents are don't-care after reset or flush.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_pc_mem[r_tail]   <= r_req_pc;
      r_inst_mem[r_tail] <= rom_data_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int          DATA_W   = 32;
  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] rom_addr_o;
  logic              rom_ce_o;
  logic [DATA_W-1:0] rom_data_i;
  logic              flush_i;
  logic [ADDR_W-1:0] new_pc_i;
  logic              id_valid_o;
  logic [ADDR_W-1:0] id_pc_o;
  logic [DATA_W-1:0] id_inst_o;
  logic              id_ready_i;
  logic [2:0]        count_o;

  fetch_queue #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rom_addr_o(rom_addr_o),
    .rom_ce_o  (rom_ce_o),
    .rom_data_i(rom_data_i),
    .flush_i   (flush_i),
    .new_pc_i  (new_pc_i),
    .id_valid_o(id_valid_o),
    .id_pc_o   (id_pc_o),
    .id_inst_o (id_inst_o),
    .id_ready_i(id_ready_i),
    .count_o   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: answers exactly one cycle after a request; garbage otherwise so a
  // push in the wrong cycle is visible.
  always @(posedge clk) begin
    if (rom_ce_o === 1'b1) rom_data_i <= rom_addr_o ^ KEY;
    else                   rom_data_i <= $urandom;
  end

  // Expected instruction stream toward decode (PCs), and bookkeeping.
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  int          n_cmp;
  int          n_err;
  int          n_pop;

  // Reference model state, updated once per cycle from the rules:
  // occupancy, one-bit in-flight flag, and the address the next issue uses.
  int          m_count;
  int          m_inflight;
  logic [31:0] m_pc;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus. Each cycle extends the expected stream by one
  // sequential PC; reset and redirect restart the stream.
  task automatic drive(input logic r, input logic f, input logic [31:0] npc, input logic rdy);
    @(posedge clk);
    #1;
    rst        = r;
    flush_i    = f;
    new_pc_i   = npc;
    id_ready_i = rdy;
    if (r) begin
      exp_q.delete();
      exp_next = RESET_PC;
    end else if (f) begin
      exp_q.delete();
      exp_next = npc;
    end
    exp_q.push_back(exp_next);
    exp_next = exp_next + 32'd4;
  endtask

  // Monitor: sample on the falling edge, compare against the model, pop the
  // scoreboard on every accepted head entry.
  always @(negedge clk) begin
    logic        ev;
    logic        ec;
    logic        pop;
    logic [31:0] epc;
    ev  = (m_count != 0) && (flush_i == 1'b0) && (rst == 1'b0);
    ec  = (rst == 1'b0) && (flush_i == 1'b0) && (m_count + m_inflight < DEPTH);
    pop = ev && (id_ready_i == 1'b1);
    check("id_valid", 64'(id_valid_o), 64'(ev));
    check("rom_ce", 64'(rom_ce_o), 64'(ec));
    check("count", 64'(count_o), 64'(m_count));
    if (ec && rom_ce_o === 1'b1) check("rom_addr", 64'(rom_addr_o), 64'(m_pc));
    if (ev) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_nonempty", 64'(0), 64'(1));
      end else begin
        epc = exp_q[0];
        check("id_pc", 64'(id_pc_o), 64'(epc));
        check("id_inst", 64'(id_inst_o), 64'(epc ^ KEY));
        if (pop) begin
          void'(exp_q.pop_front());
          n_pop++;
          $display("pop #%0d pc=%h inst=%h count=%0d t=%0t", n_pop, id_pc_o, id_inst_o, count_o, $time);
        end
      end
    end
    if (rst === 1'b1) begin
      m_count    = 0;
      m_inflight = 0;
      m_pc       = RESET_PC;
    end else if (flush_i === 1'b1) begin
      m_count    = 0;
      m_inflight = 0;
      m_pc       = new_pc_i;
    end else begin
      m_count    = m_count + m_inflight - (pop ? 1 : 0);
      m_inflight = ec ? 1 : 0;
      if (ec) m_pc = m_pc + 32'd4;
    end
  end

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    n_pop      = 0;
    m_count    = 0;
    m_inflight = 0;
    m_pc       = RESET_PC;
    exp_next   = RESET_PC;
    rst        = 1'b1;
    flush_i    = 1'b0;
    new_pc_i   = '0;
    id_ready_i = 1'b1;

    // Reset, then free-running stream with decode always ready.
    for (int i = 0; i < 3; i++)  drive(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 32'h0, 1'b1);
    // Decode stalls: queue fills to DEPTH and fetch stops; then drains.
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 32'h0, 1'b1);
    // Single-cycle redirect with decode ready.
    drive(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 32'h0, 1'b1);
    // Redirect near the top of the address space: PC wraps to zero.
    drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 32'h0, 1'b1);
    // Full queue with a request in flight, then one-cycle reset.
    drive(1'b0, 1'b1, 32'h0000_0200, 1'b0);
    for (int i = 0; i < 4; i++)  drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 32'h0, 1'b1);
    // Multi-cycle redirect.
    drive(1'b0, 1'b1, 32'h0000_0400, 1'b1);
    drive(1'b0, 1'b1, 32'h0000_0800, 1'b1);
    drive(1'b0, 1'b1, 32'h0000_0C00, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 32'h0, 1'b1);
    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      logic r;
      logic f;
      logic rdy;
      logic [31:0] npc;
      r   = ($urandom_range(0, 96) == 0);
      f   = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      npc = $urandom & 32'hFFFF_FFFC;
      drive(r, f, npc, rdy);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    #1;
    check("pops_seen", 64'(n_pop > 100), 64'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
